// File: rtl/svm_sequencer.sv
// svm_sequencer: sequences one query vector through a NUM_FEAT-stage MAC chain
// against NUM_SV support vectors streamed from a 1-cycle-latency SV memory.
// Latency: accept in cycle a, res_valid first high in cycle a+NUM_SV+NUM_FEAT+2.
// Backpressure: in_ready only in IDLE; res/res_valid held until res_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        query handshake, in_vector sampled on accept
//   sv_rd/sv_addr/sv_data    SV memory port, sv_data valid the cycle after sv_rd
//   chain_vector             query to stage 0 curr_vector_in
//   chain_accum_in           seed to stage 0 accum_in
//   chain_sv[k]              SV element k to stage k, skewed by k cycles
//   chain_start/chain_last   per-stage start_inner/last_inner, skewed by k cycles
//   chain_accum_out          final stage accum_out
//   res_valid/res_ready/res  result handshake
//
// Optional feature: define SVM_SEQ_BIAS_EN to seed the chain with BIAS
// (sign-extended) instead of zero.

module svm_sequencer #(
    parameter int DATA_SIZE    = 32,
    parameter int ACCUM_SIZE   = 64,
    parameter int NUM_FEAT     = 2,
    parameter int NUM_SV       = 4,
    parameter int SV_ADDR_SIZE = 8,
    parameter int BIAS         = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_FEAT-1:0][DATA_SIZE-1:0]  in_vector,
    output logic                                sv_rd,
    output logic [SV_ADDR_SIZE-1:0]             sv_addr,
    input  logic [NUM_FEAT-1:0][DATA_SIZE-1:0]  sv_data,
    output logic [NUM_FEAT-1:0][DATA_SIZE-1:0]  chain_vector,
    output logic [ACCUM_SIZE-1:0]               chain_accum_in,
    output logic [NUM_FEAT-1:0][DATA_SIZE-1:0]  chain_sv,
    output logic [NUM_FEAT-1:0]                 chain_start,
    output logic [NUM_FEAT-1:0]                 chain_last,
    input  logic [ACCUM_SIZE-1:0]               chain_accum_out,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ACCUM_SIZE-1:0]               res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Drain counter counts 0..NUM_FEAT.
    localparam int CNT_W = $clog2(NUM_FEAT + 2);
    localparam logic [SV_ADDR_SIZE-1:0] LAST_ADDR = SV_ADDR_SIZE'(NUM_SV - 1);
    localparam logic [CNT_W-1:0]        DRAIN_END = CNT_W'(NUM_FEAT);

    state_t                               state;
    logic [CNT_W-1:0]                     drain_cnt;
    logic                                 rd_q;        // sv_rd delayed: sv_data is valid
    logic [NUM_FEAT-1:0]                  start_sr;
    logic [NUM_FEAT-1:0]                  last_sr;
    logic [NUM_FEAT-1:0][DATA_SIZE-1:0]   query_q;
    logic [NUM_FEAT-1:0][DATA_SIZE-1:0]   sv_gated;

    wire accept = (state == IDLE) && in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            sv_rd     <= 1'b0;
            sv_addr   <= '0;
            drain_cnt <= '0;
            rd_q      <= 1'b0;
            start_sr  <= '0;
            last_sr   <= '0;
            query_q   <= '0;
            res_valid <= 1'b0;
            res       <= '0;
        end else begin
            rd_q <= sv_rd;
            // Stage-0 strobes are registered copies of sv_rd qualified by the
            // address being read, so they line up with the returned row.
            start_sr[0] <= sv_rd && (sv_addr == '0);
            last_sr[0]  <= sv_rd && (sv_addr == LAST_ADDR);
            for (int k = 1; k < NUM_FEAT; k++) begin
                start_sr[k] <= start_sr[k-1];
                last_sr[k]  <= last_sr[k-1];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        query_q  <= in_vector;
                        in_ready <= 1'b0;
                        sv_rd    <= 1'b1;
                        sv_addr  <= '0;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    if (sv_addr == LAST_ADDR) begin
                        sv_rd     <= 1'b0;
                        sv_addr   <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        sv_addr <= sv_addr + SV_ADDR_SIZE'(1);
                    end
                end
                DRAIN: begin
                    // Last row leaves the final stage NUM_FEAT cycles after
                    // it enters stage 0; capture on the last drain cycle.
                    if (drain_cnt == DRAIN_END) begin
                        res       <= chain_accum_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        query_q   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory output is only meaningful while a row is in flight; forcing it to
    // zero otherwise keeps chain_sv quiet in idle and after reset.
    assign sv_gated = rd_q ? sv_data : '0;

    assign chain_sv[0] = sv_gated[0];

    // Element k travels through a k-deep delay line to reach stage k.
    for (genvar k = 1; k < NUM_FEAT; k++) begin : g_skew
        logic [k-1:0][DATA_SIZE-1:0] dl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dl <= '0;
            end else begin
                dl[0] <= sv_gated[k];
                for (int i = 1; i < k; i++) begin
                    dl[i] <= dl[i-1];
                end
            end
        end

        assign chain_sv[k] = dl[k-1];
    end

    assign chain_start  = start_sr;
    assign chain_last   = last_sr;
    assign chain_vector = query_q;

`ifdef SVM_SEQ_BIAS_EN
    logic [ACCUM_SIZE-1:0] accum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accum_q <= '0;
        end else if (accept) begin
            accum_q <= ACCUM_SIZE'(signed'(BIAS));
        end else if (state == DONE && res_ready) begin
            accum_q <= '0;
        end
    end

    assign chain_accum_in = accum_q;
`else
    assign chain_accum_in = '0;
`endif

endmodule
